csa_sum_accum: RTL

CSA_SUM_ACCUM -- requirements
Module: csa_sum_accum

---
 rtl/csa_sum_accum.sv | 129 ++++++++++++
 1 files changed

// File: rtl/csa_sum_accum.sv
// csa_sum_accum: accumulates NUM_TERMS carry-save results ({in_cout,in_sum})
// into one ACC_W-bit total per group, with a sticky carry-out flag. The
// finished group is held on the outputs until downstream accepts it.
module csa_sum_accum #(
  parameter int NUM_TERMS = 4,
  parameter int ACC_W     = 13
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [7:0]       in_sum,
  input  logic             in_cout,
  output logic             in_ready,
  output logic             out_valid,
  output logic [ACC_W-1:0] out_total,
  output logic             out_overflow,
  input  logic             out_ready,
  output logic [4:0]       term_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ACCUM = 2'b01,
    HOLD  = 2'b10
  } state_t;

  localparam logic [4:0] LAST_CNT = 5'(NUM_TERMS);

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [4:0]       cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;

  // Incoming term zero-extended, and the running sum with one carry bit.
  logic [ACC_W-1:0] value_s;
  logic [ACC_W:0]   sum_s;
  logic [4:0]       cnt_inc_s;

  // Zero-extend the 9-bit term and form the widened running sum.
  always_comb begin
    value_s   = ACC_W'({in_cout, in_sum});
    sum_s     = {1'b0, acc_q} + {1'b0, value_s};
    cnt_inc_s = cnt_q + 5'd1;
  end

  // Next-state logic: accept terms in IDLE/ACCUM, park the result in HOLD.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          acc_d   = value_s;
          ovf_d   = 1'b0;
          cnt_d   = 5'd1;
          state_d = ACCUM;
        end else begin
          state_d = IDLE;
        end
      end
      ACCUM: begin
        if (in_valid) begin
          acc_d = sum_s[ACC_W-1:0];
          ovf_d = ovf_q | sum_s[ACC_W];
          cnt_d = cnt_inc_s;
          if (cnt_inc_s == LAST_CNT) begin
            state_d = HOLD;
          end else begin
            state_d = ACCUM;
          end
        end else begin
          state_d = ACCUM;
        end
      end
      HOLD: begin
        // Total and flag are left in place; only the term count restarts.
        if (out_ready) begin
          cnt_d   = 5'd0;
          state_d = IDLE;
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        // Unused encoding: fall back to a clean idle state.
        state_d = IDLE;
        acc_d   = {ACC_W{1'b0}};
        ovf_d   = 1'b0;
        cnt_d   = 5'd0;
      end
    endcase
  end

  // Handshake flags are precomputed from the next state so they come from flops.
  always_comb begin
    out_valid_d = (state_d == HOLD);
    in_ready_d  = (state_d != HOLD);
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= {ACC_W{1'b0}};
      ovf_q       <= 1'b0;
      cnt_q       <= 5'd0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = out_valid_q;
  assign out_total    = acc_q;
  assign out_overflow = ovf_q;
  assign term_cnt     = cnt_q;

endmodule
